mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous memory between two requesters: instruction fetch (read-only) and data memory access (loads and stores).
- Replaces the fixed "data access active" address mux.
- Issues at most one memory operation per cycle.
- Tracks in-flight reads in an owner pipeline so each read response is routed to the requester that issued it.
- Gives data accesses priority, with an anti-starvation counter that guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch
//   (read-only) and data access (loads/stores). One operation is issued per
//   cycle. Data wins by default; a saturating starvation counter forces a
//   fetch grant after STARVE_LIMIT consecutive denied fetch cycles. Every
//   issued read is tagged in an owner pipeline MEM_LATENCY deep so that the
//   returning data is steered to the requester that issued it.
//
// Ports
//   clk, rst_async          clock (rising edge), async active-low reset
//   if_req/if_addr          fetch read request and address
//   if_gnt                  fetch request accepted this cycle (combinational)
//   if_rvalid/if_rdata      fetch read response
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_gnt                   data request accepted this cycle (combinational)
//   d_rvalid/d_rdata        load response
//   mem_address/mem_write_en/mem_write_value  memory command
//   mem_read_value          memory read data, MEM_LATENCY cycles after address
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_async,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write_en,
   output logic [DATA_W-1:0] mem_write_value,
   input  logic [DATA_W-1:0] mem_read_value
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam int LAST = MEM_LATENCY - 1;

   logic [CNT_W-1:0]       starve_q, starve_d;
   // vld: a read occupies the stage; own: 1 = data side, 0 = fetch side
   logic [MEM_LATENCY-1:0] vld_q, vld_d;
   logic [MEM_LATENCY-1:0] own_q, own_d;
   logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]      d_rdata_q, d_rdata_d;

   logic force_if;
   logic d_win;
   logic i_win;
   logic rd_issue;
   logic resp_if;
   logic resp_d;

   always_comb begin
      force_if = (starve_q == LIMIT);
      // Grants are combinational, so they are gated by reset directly to
      // keep every output quiet the moment reset asserts.
      d_win    = rst_async && d_req && !(force_if && if_req);
      i_win    = rst_async && if_req && !d_win;
      rd_issue = (d_win && !d_we) || i_win;
      resp_if  = vld_q[LAST] && !own_q[LAST];
      resp_d   = vld_q[LAST] && own_q[LAST];
   end

   assign if_gnt          = i_win;
   assign d_gnt           = d_win;
   assign mem_address     = d_win ? d_addr : (i_win ? if_addr : '0);
   assign mem_write_en    = d_win && d_we;
   assign mem_write_value = d_win ? d_wdata : '0;

   // Response data passes straight through in the response cycle and is
   // otherwise held from the last response of that requester.
   assign if_rvalid = resp_if;
   assign d_rvalid  = resp_d;
   assign if_rdata  = resp_if ? mem_read_value : if_rdata_q;
   assign d_rdata   = resp_d  ? mem_read_value : d_rdata_q;

   always_comb begin
      vld_d    = vld_q;
      own_d    = own_q;
      vld_d[0] = rd_issue;
      own_d[0] = d_win;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         own_d[i] = own_q[i-1];
      end

      if (!if_req || i_win) begin
         starve_d = '0;
      end else if (starve_q != LIMIT) begin
         starve_d = starve_q + 1'b1;
      end else begin
         starve_d = starve_q;
      end

      if_rdata_d = resp_if ? mem_read_value : if_rdata_q;
      d_rdata_d  = resp_d  ? mem_read_value : d_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) begin
         starve_q   <= '0;
         vld_q      <= '0;
         own_q      <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         starve_q   <= starve_d;
         vld_q      <= vld_d;
         own_q      <= own_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int AW  = 20;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_async;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;

   logic          if_gnt_w   [2];
   logic          if_rvalid_w[2];
   logic [DW-1:0] if_rdata_w [2];
   logic          d_gnt_w    [2];
   logic          d_rvalid_w [2];
   logic [DW-1:0] d_rdata_w  [2];
   logic [AW-1:0] mem_addr_w [2];
   logic          mem_we_w   [2];
   logic [DW-1:0] mem_wv_w   [2];
   logic [DW-1:0] mem_rv_w   [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .STARVE_LIMIT(LIM)) u_l1 (
      .clk(clk), .rst_async(rst_async),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[0]),
      .if_rvalid(if_rvalid_w[0]), .if_rdata(if_rdata_w[0]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_w[0]), .d_rvalid(d_rvalid_w[0]), .d_rdata(d_rdata_w[0]),
      .mem_address(mem_addr_w[0]), .mem_write_en(mem_we_w[0]),
      .mem_write_value(mem_wv_w[0]), .mem_read_value(mem_rv_w[0]));

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .STARVE_LIMIT(LIM)) u_l3 (
      .clk(clk), .rst_async(rst_async),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[1]),
      .if_rvalid(if_rvalid_w[1]), .if_rdata(if_rdata_w[1]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_w[1]), .d_rvalid(d_rvalid_w[1]), .d_rdata(d_rdata_w[1]),
      .mem_address(mem_addr_w[1]), .mem_write_en(mem_we_w[1]),
      .mem_write_value(mem_wv_w[1]), .mem_read_value(mem_rv_w[1]));

   // Memory behaviour driven by what each DUT presents on its memory port
   logic [DW-1:0] bmem0 [logic [AW-1:0]];
   logic [DW-1:0] bmem1 [logic [AW-1:0]];
   logic [DW-1:0] p1;
   logic [DW-1:0] p3 [3];
   assign mem_rv_w[0] = p1;
   assign mem_rv_w[1] = p3[2];

   // Reference model state
   logic [DW-1:0] refmem [logic [AW-1:0]];
   bit            resp_v   [2][1024];
   bit            resp_own [2][1024];
   logic [DW-1:0] resp_dat [2][1024];
   logic [DW-1:0] last_if [2];
   logic [DW-1:0] last_d  [2];
   int            starve, cyc_n, passed, total;
   logic          m_egd, m_egi;

   // Values seen at the most recent check point
   logic          s_ig[2], s_dg[2], s_irv[2], s_drv[2], s_we[2];
   logic [DW-1:0] s_ird[2], s_drd[2], s_wv[2];
   logic [AW-1:0] s_ma[2];

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return (a == 20'h00010) ? 32'hDEADBEEF : {12'hA5C, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_zero(input string tg);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s L%0d if_gnt", tg, lat(k)), 64'(if_gnt_w[k]), 64'(0));
         chk($sformatf("%s L%0d d_gnt", tg, lat(k)), 64'(d_gnt_w[k]), 64'(0));
         chk($sformatf("%s L%0d if_rvalid", tg, lat(k)), 64'(if_rvalid_w[k]), 64'(0));
         chk($sformatf("%s L%0d d_rvalid", tg, lat(k)), 64'(d_rvalid_w[k]), 64'(0));
         chk($sformatf("%s L%0d mem_we", tg, lat(k)), 64'(mem_we_w[k]), 64'(0));
         chk($sformatf("%s L%0d mem_addr", tg, lat(k)), 64'(mem_addr_w[k]), 64'(0));
         chk($sformatf("%s L%0d mem_wv", tg, lat(k)), 64'(mem_wv_w[k]), 64'(0));
         chk($sformatf("%s L%0d if_rdata", tg, lat(k)), 64'(if_rdata_w[k]), 64'(0));
         chk($sformatf("%s L%0d d_rdata", tg, lat(k)), 64'(d_rdata_w[k]), 64'(0));
      end
   endtask

   task automatic model_reset();
      starve = 0;
      for (int k = 0; k < 2; k++) begin
         for (int c = cyc_n; c < 1024; c++) resp_v[k][c] = 1'b0;
         last_if[k] = '0;
         last_d[k]  = '0;
      end
   endtask

   // One clock cycle: check at the falling edge, advance model after the rise
   task automatic cyc();
      logic          frc, egd, egi, ewe, rvi, rvd;
      logic [AW-1:0] ea, ra;
      logic [DW-1:0] ewv, rd, v;
      @(negedge clk);
      frc = (starve == LIM);
      egd = d_req && !(frc && if_req);
      egi = if_req && !egd;
      ea  = egd ? d_addr : (egi ? if_addr : '0);
      ewe = egd && d_we;
      ewv = egd ? d_wdata : '0;
      for (int k = 0; k < 2; k++) begin
         rvi = resp_v[k][cyc_n] && !resp_own[k][cyc_n];
         rvd = resp_v[k][cyc_n] && resp_own[k][cyc_n];
         s_ig[k] = if_gnt_w[k];   s_dg[k] = d_gnt_w[k];
         s_irv[k] = if_rvalid_w[k]; s_drv[k] = d_rvalid_w[k];
         s_ird[k] = if_rdata_w[k]; s_drd[k] = d_rdata_w[k];
         s_ma[k] = mem_addr_w[k]; s_we[k] = mem_we_w[k]; s_wv[k] = mem_wv_w[k];
         chk($sformatf("c%0d L%0d if_gnt", cyc_n, lat(k)), 64'(s_ig[k]), 64'(egi));
         chk($sformatf("c%0d L%0d d_gnt", cyc_n, lat(k)), 64'(s_dg[k]), 64'(egd));
         chk($sformatf("c%0d L%0d mem_addr", cyc_n, lat(k)), 64'(s_ma[k]), 64'(ea));
         chk($sformatf("c%0d L%0d mem_we", cyc_n, lat(k)), 64'(s_we[k]), 64'(ewe));
         chk($sformatf("c%0d L%0d mem_wv", cyc_n, lat(k)), 64'(s_wv[k]), 64'(ewv));
         chk($sformatf("c%0d L%0d if_rvalid", cyc_n, lat(k)), 64'(s_irv[k]), 64'(rvi));
         chk($sformatf("c%0d L%0d d_rvalid", cyc_n, lat(k)), 64'(s_drv[k]), 64'(rvd));
         chk($sformatf("c%0d L%0d if_rdata", cyc_n, lat(k)), 64'(s_ird[k]),
             64'(rvi ? resp_dat[k][cyc_n] : last_if[k]));
         chk($sformatf("c%0d L%0d d_rdata", cyc_n, lat(k)), 64'(s_drd[k]),
             64'(rvd ? resp_dat[k][cyc_n] : last_d[k]));
      end
      @(posedge clk);
      if (ewe) refmem[d_addr] = d_wdata;
      if ((egd && !d_we) || egi) begin
         ra = egd ? d_addr : if_addr;
         rd = refmem.exists(ra) ? refmem[ra] : dflt(ra);
         for (int k = 0; k < 2; k++) begin
            resp_v[k][cyc_n + lat(k)]   = 1'b1;
            resp_own[k][cyc_n + lat(k)] = egd;
            resp_dat[k][cyc_n + lat(k)] = rd;
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (resp_v[k][cyc_n]) begin
            if (resp_own[k][cyc_n]) last_d[k] = resp_dat[k][cyc_n];
            else                    last_if[k] = resp_dat[k][cyc_n];
         end
      end
      if (!if_req || egi) starve = 0;
      else if (starve < LIM) starve++;
      m_egd = egd;
      m_egi = egi;
      cyc_n++;
      #1;
      // write-first memory: a write is visible to any later read
      if (s_we[0]) bmem0[s_ma[0]] = s_wv[0];
      v  = bmem0.exists(s_ma[0]) ? bmem0[s_ma[0]] : dflt(s_ma[0]);
      p1 = v;
      if (s_we[1]) bmem1[s_ma[1]] = s_wv[1];
      v  = bmem1.exists(s_ma[1]) ? bmem1[s_ma[1]] : dflt(s_ma[1]);
      p3[2] = p3[1];
      p3[1] = p3[0];
      p3[0] = v;
   endtask

   task automatic idle(input int n);
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      logic i_pend, d_pend;
      passed = 0; total = 0; cyc_n = 0; starve = 0;
      p1 = '0; p3[0] = '0; p3[1] = '0; p3[2] = '0;
      m_egd = 1'b0; m_egi = 1'b0;
      model_reset();

      // Reset with both requests active: everything must be quiet
      rst_async = 1'b0;
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
      if_addr = 20'h00010; d_addr = 20'h00055; d_wdata = 32'h0000FFFF;
      #2;
      chk_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      rst_async = 1'b1;

      // Single fetch after reset
      if_req = 1'b1; if_addr = 20'h00010;
      cyc();
      chk("t1 if_gnt", 64'(s_ig[0]), 64'(1));
      chk("t1 d_gnt", 64'(s_dg[0]), 64'(0));
      chk("t1 mem_we", 64'(s_we[0]), 64'(0));
      if_req = 1'b0;
      cyc();
      chk("t1 if_rvalid", 64'(s_irv[0]), 64'(1));
      chk("t1 if_rdata", 64'(s_ird[0]), 64'(32'hDEADBEEF));
      chk("t1 d_rvalid", 64'(s_drv[0]), 64'(0));
      idle(3);

      // Both requesting: data wins, response routed to data
      d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00100;
      if_req = 1'b1; if_addr = 20'h00020;
      cyc();
      chk("t2 d_gnt", 64'(s_dg[0]), 64'(1));
      chk("t2 mem_addr", 64'(s_ma[0]), 64'(20'h00100));
      d_req = 1'b0;
      cyc();
      chk("t2 d_rvalid", 64'(s_drv[0]), 64'(1));
      chk("t2 if_rvalid", 64'(s_irv[0]), 64'(0));
      idle(4);

      // Starvation limit forces every fifth grant to fetch
      d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00200;
      if_req = 1'b1; if_addr = 20'h00030;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("t3 d_gnt %0d", i), 64'(s_dg[0]), 64'(i % 5 != 4));
         chk($sformatf("t3 if_gnt %0d", i), 64'(s_ig[0]), 64'(i % 5 == 4));
         if (i % 5 == 4) chk($sformatf("t3 mem_addr %0d", i), 64'(s_ma[0]), 64'(20'h00030));
      end
      idle(4);

      // Store then load of the same address
      d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00040; d_wdata = 32'h12345678;
      cyc();
      chk("t4 mem_we", 64'(s_we[0]), 64'(1));
      chk("t4 d_rvalid c0", 64'(s_drv[0]), 64'(0));
      d_we = 1'b0;
      cyc();
      chk("t4 d_rvalid c1", 64'(s_drv[0]), 64'(0));
      d_req = 1'b0;
      cyc();
      chk("t4 d_rvalid c2", 64'(s_drv[0]), 64'(1));
      chk("t4 d_rdata c2", 64'(s_drd[0]), 64'(32'h12345678));
      idle(4);

      // Alternating fetch/data reads, checked on the three-cycle instance
      for (int i = 0; i < 15; i++) begin
         if (i < 12) begin
            if_req = (i % 2 == 0);
            d_req  = (i % 2 == 1);
            d_we   = 1'b0;
            if_addr = 20'h00040 + 20'($urandom_range(0, 15));
            d_addr  = 20'h00040 + 20'($urandom_range(0, 15));
         end else begin
            if_req = 1'b0; d_req = 1'b0;
         end
         cyc();
         if (i >= 3) begin
            chk($sformatf("t5 L3 if_rvalid %0d", i), 64'(s_irv[1]), 64'((i - 3) % 2 == 0 && i < 15));
            chk($sformatf("t5 L3 d_rvalid %0d", i), 64'(s_drv[1]), 64'((i - 3) % 2 == 1));
         end
      end
      idle(3);

      // Randomized traffic: requests held until granted, back-to-back allowed
      i_pend = 1'b0; d_pend = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!i_pend) begin
            if ($urandom_range(0, 4) != 0) begin
               if_req = 1'b1;
               if_addr = 20'h00040 + 20'($urandom_range(0, 15));
               i_pend = 1'b1;
            end else begin
               if_req = 1'b0;
            end
         end
         if (!d_pend) begin
            if ($urandom_range(0, 3) != 0) begin
               d_req = 1'b1;
               d_we = 1'($urandom_range(0, 1));
               d_addr = 20'h00040 + 20'($urandom_range(0, 15));
               d_wdata = $urandom;
               d_pend = 1'b1;
            end else begin
               d_req = 1'b0;
            end
         end
         cyc();
         if (m_egi) i_pend = 1'b0;
         if (m_egd) d_pend = 1'b0;
      end
      idle(4);

      // Reset while two reads are in flight
      if_req = 1'b1; if_addr = 20'h00041;
      cyc();
      if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00042;
      cyc();
      if_req = 1'b1; d_req = 1'b1;
      #2;
      rst_async = 1'b0;
      #1;
      chk_zero("t6 async");
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      rst_async = 1'b1;
      if_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("t6 L3 if_rvalid %0d", i), 64'(s_irv[1]), 64'(0));
         chk($sformatf("t6 L3 d_rvalid %0d", i), 64'(s_drv[1]), 64'(0));
      end
      d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00043;
      if_req = 1'b1; if_addr = 20'h00044;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("t6 starve if_gnt %0d", i), 64'(s_ig[0]), 64'(i == 4));
      end
      idle(4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
